// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolution signals between the core and the branch predictor.
// The core drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [XLEN-1:0]  lookup_pc;
  logic             predict_taken;
  logic [XLEN-1:0]  predict_target;
  logic             update_valid;
  logic [XLEN-1:0]  update_pc;
  logic             update_is_jump;
  logic             update_taken;
  logic [XLEN-1:0]  update_target;
  logic             update_pred_taken;
  logic [XLEN-1:0]  update_pred_target;
  logic             flush_table;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output lookup_pc, update_valid, update_pc, update_is_jump, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_table,
    input  predict_taken, predict_target, mispredict, redirect_pc, branch_count,
           mispredict_count
  );

  modport slave (
    input  lookup_pc, update_valid, update_pc, update_is_jump, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_table,
    output predict_taken, predict_target, mispredict, redirect_pc, branch_count,
           mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + saturating-counter BHT with combinational lookup and mispredict
// detection, trained on EX-stage resolution, plus branch/mispredict performance counters.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned CNT_W    = 32
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CtrMax    = '1;
  localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CtrWeakT - CTR_BITS'(1);

  // valid/ctr are reset; tag/target/is_jump are only ever read behind a valid bit
  logic                valid_q  [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic                jump_q   [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispredict_count_q;

  // Lookup
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag = bus.lookup_pc[IDX_W+1+TAG_BITS:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.predict_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
  assign bus.predict_target = bus.predict_taken ? target_q[lk_idx]
                                                : bus.lookup_pc + XLEN'(4);

  // Resolution
  logic [XLEN-1:0] upd_pc_plus4;
  logic [XLEN-1:0] actual_pc;
  logic [XLEN-1:0] predicted_pc;

  assign upd_pc_plus4 = bus.update_pc + XLEN'(4);
  assign actual_pc    = bus.update_taken ? bus.update_target : upd_pc_plus4;
  assign predicted_pc = bus.update_pred_taken ? bus.update_pred_target : upd_pc_plus4;
  assign bus.mispredict  = bus.update_valid && (actual_pc != predicted_pc);
  assign bus.redirect_pc = bus.mispredict ? actual_pc : upd_pc_plus4;

  // Training
  logic [IDX_W-1:0]    up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic                ent_we;
  logic                ent_valid_d;
  logic [CTR_BITS-1:0] ent_ctr_d;
  logic                fld_we;

  assign up_idx = bus.update_pc[IDX_W+1:2];
  assign up_tag = bus.update_pc[IDX_W+1+TAG_BITS:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    ent_we      = 1'b0;
    ent_valid_d = valid_q[up_idx];
    ent_ctr_d   = ctr_q[up_idx];
    fld_we      = 1'b0;
    if (bus.update_valid && !bus.flush_table) begin
      if (up_hit) begin
        if (!bus.update_is_jump) begin
          ent_we = 1'b1;
          if (bus.update_taken && (ctr_q[up_idx] != CtrMax)) begin
            ent_ctr_d = ctr_q[up_idx] + CTR_BITS'(1);
          end else if (!bus.update_taken && (ctr_q[up_idx] != '0)) begin
            ent_ctr_d = ctr_q[up_idx] - CTR_BITS'(1);
          end
        end
        fld_we = bus.update_taken;
      end else if (bus.update_taken) begin
        ent_we      = 1'b1;
        ent_valid_d = 1'b1;
        ent_ctr_d   = CtrWeakT;
        fld_we      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrWeakNt;
      end
    end else if (bus.flush_table) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrWeakNt;
      end
    end else if (ent_we) begin
      valid_q[up_idx] <= ent_valid_d;
      ctr_q[up_idx]   <= ent_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fld_we) begin
      tag_q[up_idx]    <= up_tag;
      jump_q[up_idx]   <= bus.update_is_jump;
      target_q[up_idx] <= bus.update_target;
    end
  end

  // Counters also count updates that coincide with a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.update_valid) begin
      branch_count_q     <= branch_count_q + CNT_W'(1);
      mispredict_count_q <= mispredict_count_q + CNT_W'(bus.mispredict);
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor against an arithmetic table model, with a per-cycle
// compare process and hand-computed literal expectations at key points.
module tb_branch_predictor;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ENTRIES  = 64;
  localparam int unsigned TAG_BITS = 8;
  localparam int unsigned CTR_BITS = 2;
  localparam int unsigned CNT_W    = 32;
  localparam int CtrTop = (1 << CTR_BITS) - 1;
  localparam int Half   = 1 << (CTR_BITS - 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: table indexed by word address modulo ENTRIES, counters as plain ints
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  bit          m_jump   [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_bc = '0;
  logic [31:0] m_mc = '0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_BITS);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_jump[idx_of(pc)] || (m_ctr[idx_of(pc)] >= Half));
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return bus.update_taken ? bus.update_target : bus.update_pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    logic [31:0] predicted;
    predicted = bus.update_pred_taken ? bus.update_pred_target : bus.update_pc + 32'd4;
    return bus.update_valid && (m_actual() != predicted);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = Half - 1;
      end
      m_bc = '0;
      m_mc = '0;
    end else begin
      if (bus.update_valid) begin
        m_bc = m_bc + 1;
        if (m_mis()) m_mc = m_mc + 1;
      end
      if (bus.flush_table) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          m_valid[i] = 1'b0;
          m_ctr[i]   = Half - 1;
        end
      end else if (bus.update_valid) begin
        automatic int i = idx_of(bus.update_pc);
        if (m_hit(bus.update_pc)) begin
          if (!bus.update_is_jump) begin
            if (bus.update_taken) m_ctr[i] = (m_ctr[i] < CtrTop) ? m_ctr[i] + 1 : CtrTop;
            else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
          if (bus.update_taken) begin
            m_target[i] = bus.update_target;
            m_jump[i]   = bus.update_is_jump;
          end
        end else if (bus.update_taken) begin
          m_valid[i]  = 1'b1;
          m_tag[i]    = tag_of(bus.update_pc);
          m_target[i] = bus.update_target;
          m_jump[i]   = bus.update_is_jump;
          m_ctr[i]    = Half;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("predict_taken", bus.predict_taken, m_pred_taken(bus.lookup_pc));
    chk("predict_target", bus.predict_target, m_pred_target(bus.lookup_pc));
    chk("mispredict", bus.mispredict, m_mis());
    chk("redirect_pc", bus.redirect_pc, m_mis() ? m_actual() : bus.update_pc + 32'd4);
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
  end

  task automatic upd(input logic [31:0] pc, input bit is_jump, input bit taken,
                     input logic [31:0] target, input bit pred_taken,
                     input logic [31:0] pred_target);
    bus.update_valid       = 1'b1;
    bus.update_pc          = pc;
    bus.update_is_jump     = is_jump;
    bus.update_taken       = taken;
    bus.update_target      = target;
    bus.update_pred_taken  = pred_taken;
    bus.update_pred_target = pred_target;
  endtask

  task automatic nop();
    bus.update_valid = 1'b0;
    bus.flush_table  = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.lookup_pc = 32'h100;
    bus.update_pc = '0;
    bus.update_is_jump = 1'b0;
    bus.update_taken = 1'b0;
    bus.update_target = '0;
    bus.update_pred_taken = 1'b0;
    bus.update_pred_target = '0;
    nop();
    #1 reset = 1'b1;
    #1;
    chk("rst_pt", bus.predict_taken, 1'b0);
    chk("rst_target", bus.predict_target, 32'h104);
    chk("rst_bc", bus.branch_count, 32'd0);
    chk("rst_mc", bus.mispredict_count, 32'd0);
    @(posedge clk);
    next();
    reset = 1'b0;

    // First taken branch allocates; lookup in the same cycle still sees a miss
    upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    @(negedge clk);
    chk("alloc_mis", bus.mispredict, 1'b1);
    chk("alloc_redirect", bus.redirect_pc, 32'h200);
    chk("alloc_same_cycle_pt", bus.predict_taken, 1'b0);
    next();
    nop();
    @(negedge clk);
    chk("after_alloc_pt", bus.predict_taken, 1'b1);
    chk("after_alloc_target", bus.predict_target, 32'h200);
    chk("after_alloc_bc", bus.branch_count, 32'd1);
    chk("after_alloc_mc", bus.mispredict_count, 32'd1);
    next();

    // ctr 2 -> 1 -> 0 -> 0
    upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    @(negedge clk);
    chk("nt1_mis", bus.mispredict, 1'b1);
    chk("nt1_redirect", bus.redirect_pc, 32'h104);
    next();
    upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("nt2_pt", bus.predict_taken, 1'b0);
    chk("nt2_mis", bus.mispredict, 1'b0);
    next();
    next();

    // Four taken saturate at 3; one not-taken must leave the prediction taken
    upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) next();
    upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    @(negedge clk);
    chk("sat_pt", bus.predict_taken, 1'b1);
    next();
    nop();
    @(negedge clk);
    chk("sat_nowrap_pt", bus.predict_taken, 1'b1);
    next();

    // Aliasing: 0x200 evicts 0x100
    upd(32'h200, 1'b0, 1'b1, 32'h280, 1'b0, 32'h0);
    next();
    nop();
    @(negedge clk);
    chk("alias_pt", bus.predict_taken, 1'b0);
    chk("alias_target", bus.predict_target, 32'h104);
    next();
    bus.lookup_pc = 32'h200;
    @(negedge clk);
    chk("alias_new_target", bus.predict_target, 32'h280);
    next();

    // jal, then flush coinciding with an update
    upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    next();
    nop();
    bus.lookup_pc = 32'h40;
    @(negedge clk);
    chk("jal_pt", bus.predict_taken, 1'b1);
    chk("jal_target", bus.predict_target, 32'h80);
    next();
    upd(32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    bus.flush_table = 1'b1;
    @(negedge clk);
    chk("flush_mis", bus.mispredict, 1'b1);
    next();
    nop();
    @(negedge clk);
    chk("flush_pt", bus.predict_taken, 1'b0);
    chk("flush_target", bus.predict_target, 32'h44);
    next();
    bus.lookup_pc = 32'h500;
    @(negedge clk);
    chk("flush_no_alloc_pt", bus.predict_taken, 1'b0);
    next();

    // Same-cycle lookup/update, then asynchronous reset mid-cycle
    bus.lookup_pc = 32'h300;
    upd(32'h300, 1'b0, 1'b1, 32'h340, 1'b0, 32'h0);
    @(negedge clk);
    chk("same_cycle_pt", bus.predict_taken, 1'b0);
    chk("same_cycle_target", bus.predict_target, 32'h304);
    next();
    nop();
    @(negedge clk);
    chk("next_cycle_pt", bus.predict_taken, 1'b1);
    chk("next_cycle_target", bus.predict_target, 32'h340);
    next();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_pt", bus.predict_taken, 1'b0);
    chk("async_rst_target", bus.predict_target, 32'h304);
    chk("async_rst_bc", bus.branch_count, 32'd0);
    chk("async_rst_mc", bus.mispredict_count, 32'd0);
    next();
    reset = 1'b0;

    upd(32'h300, 1'b0, 1'b1, 32'h340, 1'b0, 32'h0);
    next();
    upd(32'h300, 1'b0, 1'b1, 32'h344, 1'b1, 32'h340);
    next();
    nop();
    @(negedge clk);
    chk("post_rst_target", bus.predict_target, 32'h344);
    chk("post_rst_bc", bus.branch_count, 32'd2);
    chk("post_rst_mc", bus.mispredict_count, 32'd2);
    next();
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage core.
- The fetch stage queries it each cycle with the PC and receives a predicted next-PC.
- The EX stage reports each resolved branch/jump; the block trains its BHT/BTB and flags mispredicts so the hazard unit flushes IF/ID and ID/EX.
- Replaces the current always-not-taken policy, which flushes on every taken branch. Also keeps performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BTB/BHT entries; power of two, ≥2; IDX_W = log2(ENTRIES)
TAG_BITS, 8, PC tag bits stored per entry; IDX_W+2+TAG_BITS ≤ XLEN
CTR_BITS, 2, saturating counter width, ≥1
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
lookup_pc  in  XLEN  fetch-stage PC
predict_taken  out  1  predicted taken (combinational from lookup_pc and table state)
predict_target  out  XLEN  predicted next PC
update_valid  in  1  EX stage resolved a branch or jump this cycle
update_pc  in  XLEN  PC of the resolved instruction
update_is_jump  in  1  1 = jal/jalr (unconditional), 0 = conditional branch
update_taken  in  1  actual outcome
update_target  in  XLEN  actual target (PC+imm or ALU result)
update_pred_taken  in  1  prediction made at fetch, piped down
update_pred_target  in  XLEN  predicted next PC made at fetch, piped down
flush_table  in  1  invalidate all entries (fence.i / context switch)
mispredict  out  1  combinational: resolved next-PC ≠ predicted next-PC
redirect_pc  out  XLEN  correct next PC when mispredict=1
branch_count  out  CNT_W  resolved updates since reset
mispredict_count  out  CNT_W  mispredicts since reset

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+1+TAG_BITS:IDX_W+2].
- Entry = {valid, tag, is_jump, target[XLEN], ctr[CTR_BITS]}.
- Lookup is combinational, with no added latency.
  - hit = valid & tag match.
  - predict_taken = hit & (is_jump | ctr[MSB]).
  - predict_target = predict_taken ? target : lookup_pc+4 (modulo 2^XLEN).
- Resolution is combinational on update_valid.
  - actual = update_taken ? update_target : update_pc+4.
  - predicted = update_pred_taken ? update_pred_target : update_pc+4.
  - mispredict = update_valid & (actual ≠ predicted).
  - redirect_pc = actual. redirect_pc is don't-care when mispredict=0 and is then driven to update_pc+4.
- Training is applied at the rising edge when update_valid=1.
  - Hit, conditional branch: ctr saturating increment if taken, decrement if not taken. Holds at all-ones / zero, never wraps.
  - Hit, taken: target ← update_target; is_jump ← update_is_jump.
  - Miss, taken: allocate by overwriting the indexed entry (direct-mapped, no replacement choice). valid=1, tag, target, is_jump set; ctr = weakly-taken = 1<<(CTR_BITS-1).
  - Miss, not taken: no allocation, table unchanged.
- Counters at each edge with update_valid=1:
  - branch_count += 1.
  - mispredict_count += mispredict.
  - Both wrap modulo 2^CNT_W.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new contents are visible the cycle after the edge (no write-through bypass).
- flush_table=1 at an edge:
  - All valid bits cleared; ctr reset to weakly-not-taken = (1<<(CTR_BITS-1))-1, with CTR_BITS=1 giving 0.
  - Flush wins over a same-cycle update: no training occurs.
  - Performance counters still count that update.
  - mispredict/redirect_pc are unaffected, because they are combinational.
- Reset (asynchronous, any time, including mid-stream):
  - All valid=0; ctr = weakly-not-taken; counters=0.
  - Outputs follow immediately: predict_taken=0, predict_target=lookup_pc+4, branch_count=0, mispredict_count=0.
  - mispredict=0 is guaranteed only while update_valid=0.
- No X propagation: target/tag storage need not be reset, but no output may depend on an invalid entry's fields.

Test Plan:
- Reset, then lookup_pc=0x100 → predict_taken=0, predict_target=0x104; both counters 0.
- Update pc=0x100 branch taken target=0x200, pred_taken=0 → mispredict=1, redirect_pc=0x200; next cycle lookup 0x100 → taken, 0x200; mispredict_count=1, branch_count=1.
- Same entry not-taken ×2 with CTR_BITS=2 → ctr 2→1→0; prediction becomes not-taken after the first update; a third not-taken update holds ctr at 0. Taken ×4 → saturates at 3 with no wrap.
- Aliasing with ENTRIES=64: pc=0x100 and pc=0x200 (same index, different tag), both taken → the second evicts the first; lookup 0x100 → miss, predict_target=0x104.
- Jal at pc=0x40 to 0x80 allocated → always predicted taken. Then flush_table together with an update in the same cycle → lookup 0x40 not-taken; branch_count still incremented.
- Same-cycle lookup/update on pc=0x300 allocation → lookup that cycle reports not-taken, next cycle taken. Assert reset mid-sequence → all outputs return to reset values asynchronously, before the next edge.
